// File: rtl/lgca_cell.sv
// lgca_cell: one cell of an HPP-style lattice-gas array.
//
// Occupancy bits: bit0=E, bit1=N, bit2=W, bit3=S (direction of travel).
// On each generation strobe the cell gathers the particles heading into it
// from its four neighbours. It applies the selected collision rule, ORs in any
// injected particles and registers the result.
//
// Ports
//   clk, rst_n        clock; synchronous active-low reset
//   step              generation strobe, one update per cycle it is high
//   mode              0 free flight, 1 HPP deterministic, 2 HPP stochastic, 3 wall
//   in_e/in_n/in_w/in_s  occupancy of the E/N/W/S neighbour cells
//   inject_valid/inject_dirs/inject_ready  particle injection handshake
//   clr_count         synchronous clear of coll_count
//   state             registered occupancy
//   pcount            number of particles in state
//   coll_count        saturating collision counter
module lgca_cell #(
    parameter int unsigned COUNT_W = 8,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               step,
    input  logic [1:0]         mode,
    input  logic [3:0]         in_e,
    input  logic [3:0]         in_n,
    input  logic [3:0]         in_w,
    input  logic [3:0]         in_s,
    input  logic               inject_valid,
    input  logic [3:0]         inject_dirs,
    output logic               inject_ready,
    input  logic               clr_count,
    output logic [3:0]         state,
    output logic [2:0]         pcount,
    output logic [COUNT_W-1:0] coll_count
);

    // An all-zero Galois LFSR would lock up, so a zero seed is replaced.
    localparam logic [15:0]        SeedEff  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0]        Taps     = 16'hB400;
    localparam logic [COUNT_W-1:0] CountMax = '1;
    localparam logic [COUNT_W-1:0] CountOne = {{(COUNT_W - 1){1'b0}}, 1'b1};

    logic [15:0]        lfsr_q, lfsr_d;
    logic [3:0]         state_q, state_d;
    logic [3:0]         pend_q, pend_d;
    logic               pend_v_q, pend_v_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic [3:0] arr;
    logic [3:0] rule_out;
    logic       coll;
    logic       xfer;
    logic [3:0] merge;

    // Only the particle heading towards this cell is taken from each neighbour.
    assign arr = {in_n[3], in_e[2], in_s[1], in_w[0]};

    logic unused_in;
    assign unused_in = ^{in_n[2:0], in_e[3], in_e[1:0], in_s[3:2], in_s[0], in_w[3:1]};

    always_comb begin
        rule_out = arr;
        coll     = 1'b0;
        case (mode)
            2'd0: begin
                rule_out = arr;
            end
            2'd1: begin
                // Head-on pairs (E+W or N+S only) turn by 90 degrees.
                if (arr == 4'b0101 || arr == 4'b1010) begin
                    rule_out = ~arr;
                    coll     = 1'b1;
                end
            end
            2'd2: begin
                if ((arr == 4'b0101 || arr == 4'b1010) && lfsr_q[15]) begin
                    rule_out = ~arr;
                    coll     = 1'b1;
                end
            end
            default: begin
                // Wall: every particle bounces straight back.
                rule_out = {arr[1:0], arr[3:2]};
                coll     = |arr;
            end
        endcase
    end

    assign inject_ready = ~pend_v_q;
    assign xfer         = inject_valid & ~pend_v_q;
    // Parked injection and a same-cycle bypass are mutually exclusive (xfer needs ~pend_v).
    assign merge = (pend_v_q ? pend_q : 4'b0000) | (xfer ? inject_dirs : 4'b0000);

    always_comb begin
        lfsr_d   = (lfsr_q >> 1) ^ (lfsr_q[0] ? Taps : 16'h0000);
        state_d  = state_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        count_d  = count_q;

        if (step) begin
            state_d  = rule_out | merge;
            pend_v_d = 1'b0;
        end else if (xfer) begin
            pend_d   = inject_dirs;
            pend_v_d = 1'b1;
        end

        if (clr_count) begin
            count_d = '0;
        end else if (step && coll && count_q != CountMax) begin
            count_d = count_q + CountOne;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q   <= SeedEff;
            state_q  <= 4'b0000;
            pend_q   <= 4'b0000;
            pend_v_q <= 1'b0;
            count_q  <= '0;
        end else begin
            lfsr_q   <= lfsr_d;
            state_q  <= state_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            count_q  <= count_d;
        end
    end

    assign state      = state_q;
    assign pcount     = {2'b00, state_q[0]} + {2'b00, state_q[1]}
                      + {2'b00, state_q[2]} + {2'b00, state_q[3]};
    assign coll_count = count_q;

endmodule
